// File: rtl/mips_mc_pkg.sv
// Shared types for the multi-cycle MIPS core: FSM states, opcode/funct
// constants, ALU-op codes, error codes, immediate-extension modes and the
// instruction decoder used by both the control FSM and the datapath.
package mips_mc_pkg;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI} alu_op_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_ILL, ERR_TMO, ERR_ALIGN} err_t;
    typedef enum logic       {EXT_SIGN, EXT_ZERO} ext_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR  = 6'h08, FN_ADDU = 6'h21,
                           FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR  = 6'h25,
                           FN_SLT = 6'h2A;

    typedef struct packed {
        logic    legal;
        logic    rtype;   // ALU result goes to rd
        logic    jump;    // j / jal / jr, complete in DECODE
        logic    jal;
        logic    jr;
        logic    branch;
        logic    bne;
        logic    load;
        logic    store;
        logic    imm;     // immediate ALU op, result goes to rt
        alu_op_t alu_op;
        ext_t    ext;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d        = '0;
        d.legal  = 1'b1;
        d.alu_op = ALU_ADD;
        d.ext    = EXT_SIGN;
        case (op)
            OP_RTYPE: begin
                d.rtype = 1'b1;
                case (fn)
                    FN_ADDU: d.alu_op = ALU_ADD;
                    FN_SUBU: d.alu_op = ALU_SUB;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_JR:   begin d.rtype = 1'b0; d.jump = 1'b1; d.jr = 1'b1; end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_J:     d.jump = 1'b1;
            OP_JAL:   begin d.jump = 1'b1; d.jal = 1'b1; end
            OP_BEQ:   begin d.branch = 1'b1; d.alu_op = ALU_SUB; end
            OP_BNE:   begin d.branch = 1'b1; d.bne = 1'b1; d.alu_op = ALU_SUB; end
            OP_ADDI,
            OP_ADDIU: d.imm = 1'b1;
            OP_ANDI:  begin d.imm = 1'b1; d.alu_op = ALU_AND; d.ext = EXT_ZERO; end
            OP_ORI:   begin d.imm = 1'b1; d.alu_op = ALU_OR;  d.ext = EXT_ZERO; end
            OP_LUI:   begin d.imm = 1'b1; d.alu_op = ALU_LUI; d.ext = EXT_ZERO; end
            OP_LW:    d.load = 1'b1;
            OP_SW:    d.store = 1'b1;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Memory bus between the core (master) and instruction/data memories (slave).
//   imem_*: fetch request, word address, read data, ready
//   dmem_*: data request, write enable, word address, write/read data, ready
// A transfer completes on the rising edge where req & ready.
interface mips_mc_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );
    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ready, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Control FSM of the multi-cycle core: state register, bus wait counter,
// instruction decode, request/retire strobes and sticky error code.
//   i_op/i_fn      opcode and funct of the latched IR
//   i_*_ready      memory ready inputs
//   i_addr_lo      low bits of the EXEC-cycle ALU result (load/store address)
//   o_state/o_dec  current state and decoded instruction for the datapath
//   o_*_req        memory requests, o_retire commit strobe, o_err_code
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_op,
    input  logic [5:0] i_fn,
    input  logic       i_imem_ready,
    input  logic       i_dmem_ready,
    input  logic [1:0] i_addr_lo,
    output state_t     o_state,
    output dec_t       o_dec,
    output logic       o_imem_req,
    output logic       o_dmem_req,
    output logic       o_retire,
    output logic [1:0] o_err_code
);
    localparam logic [8:0] TMO = 9'(TIMEOUT);

    state_t     r_state, w_state_n;
    logic [7:0] r_wcnt, w_wcnt_n;
    err_t       r_err, w_err_n;
    logic       w_wait;

    assign o_dec      = decode(i_op, i_fn);
    assign o_state    = r_state;
    // Reset is FETCH, but no fetch may be requested while rst_n is held low.
    assign o_imem_req = (r_state == S_FETCH) && i_rst_n;
    assign o_dmem_req = (r_state == S_MEM);
    assign o_err_code = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FETCH;
            r_wcnt  <= '0;
            r_err   <= ERR_NONE;
        end else begin
            r_state <= w_state_n;
            r_wcnt  <= w_wcnt_n;
            r_err   <= w_err_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_wcnt_n  = r_wcnt;
        w_err_n   = r_err;
        w_wait    = 1'b0;
        o_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (i_imem_ready) w_state_n = S_DECODE;
                else              w_wait    = 1'b1;
            end
            S_DECODE: begin
                if (!o_dec.legal) begin
                    w_state_n = S_HALT;
                    w_err_n   = ERR_ILL;
                end else if (o_dec.jump) begin
                    o_retire  = 1'b1;
                    w_state_n = S_FETCH;
                end else begin
                    w_state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (o_dec.branch) begin
                    o_retire  = 1'b1;
                    w_state_n = S_FETCH;
                end else if (o_dec.load || o_dec.store) begin
                    if (i_addr_lo != 2'b00) begin
                        w_state_n = S_HALT;
                        w_err_n   = ERR_ALIGN;
                    end else begin
                        w_state_n = S_MEM;
                    end
                end else begin
                    w_state_n = S_WB;
                end
            end
            S_MEM: begin
                if (i_dmem_ready) begin
                    if (o_dec.store) begin
                        o_retire  = 1'b1;
                        w_state_n = S_FETCH;
                    end else begin
                        w_state_n = S_WB;
                    end
                end else begin
                    w_wait = 1'b1;
                end
            end
            S_WB: begin
                o_retire  = 1'b1;
                w_state_n = S_FETCH;
            end
            default: ;
        endcase
        if (w_wait) begin
            if (({1'b0, r_wcnt} + 9'd1) >= TMO) begin
                w_state_n = S_HALT;
                w_err_n   = ERR_TMO;
            end else begin
                w_wcnt_n = r_wcnt + 8'd1;
            end
        end
        // Any state change restarts the wait count, so FETCH/MEM start at 0.
        if (w_state_n != r_state) w_wcnt_n = '0;
    end
endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core top: PC/IR/A/B/ALUOut/MDR, 32x32 register file and
// one ALU shared by the PC increment (FETCH), branch target (DECODE) and
// execute (EXEC) steps. Control lives in mips_mc_ctrl.
//   i_clk, i_rst_n  clock and async active-low reset
//   bus             instruction/data memory master port
//   o_retire        commit strobe, o_retire_pc PC of the committed instruction
//   o_halted        core stopped, o_err_code reason (0 none,1 illegal,2 timeout,3 misaligned)
module mips_multicycle
    import mips_mc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mips_mc_if.master   bus,
    output logic        o_retire,
    output logic [31:0] o_retire_pc,
    output logic        o_halted,
    output logic [1:0]  o_err_code
);
    logic [31:0] r_pc, r_cur_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_rf [32];
    state_t      w_state;
    dec_t        w_dec;
    alu_op_t     w_alu_op;
    logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
    logic [31:0] w_rs_data, w_rt_data, w_imm_s, w_imm_x;
    logic [31:0] w_alu_a, w_alu_b, w_alu_y, w_wdata;
    logic        w_taken, w_rf_we;

    mips_mc_ctrl #(.TIMEOUT(TIMEOUT)) u_ctrl (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_op         (r_ir[31:26]),
        .i_fn         (r_ir[5:0]),
        .i_imem_ready (bus.imem_ready),
        .i_dmem_ready (bus.dmem_ready),
        .i_addr_lo    (w_alu_y[1:0]),
        .o_state      (w_state),
        .o_dec        (w_dec),
        .o_imem_req   (bus.imem_req),
        .o_dmem_req   (bus.dmem_req),
        .o_retire     (o_retire),
        .o_err_code   (o_err_code)
    );

    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_rs_data = r_rf[w_rs];
    assign w_rt_data = r_rf[w_rt];
    assign w_imm_s   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm_x   = (w_dec.ext == EXT_ZERO) ? {16'd0, r_ir[15:0]} : w_imm_s;
    assign w_taken   = w_dec.bne ? (r_a != r_b) : (r_a == r_b);

    assign bus.imem_addr  = r_pc[ADDR_W+1:2];
    assign bus.dmem_we    = bus.dmem_req && w_dec.store;
    assign bus.dmem_addr  = r_aluout[ADDR_W+1:2];
    assign bus.dmem_wdata = r_b;
    assign o_retire_pc    = r_cur_pc;
    assign o_halted       = (w_state == S_HALT);

    // Operand steering for the shared ALU.
    always_comb begin
        w_alu_a  = r_a;
        w_alu_b  = r_b;
        w_alu_op = ALU_ADD;
        case (w_state)
            S_FETCH:  begin w_alu_a = r_pc; w_alu_b = 32'd4; end
            S_DECODE: begin w_alu_a = r_pc; w_alu_b = {w_imm_s[29:0], 2'b00}; end
            S_EXEC: begin
                w_alu_op = w_dec.alu_op;
                if (!w_dec.rtype && !w_dec.branch) w_alu_b = w_imm_x;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alu_y = '0;
        case (w_alu_op)
            ALU_ADD: w_alu_y = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            ALU_SLL: w_alu_y = w_alu_b << r_ir[10:6];
            ALU_LUI: w_alu_y = {w_alu_b[15:0], 16'd0};
            default: w_alu_y = '0;
        endcase
    end

    // jal links in DECODE (r_pc already holds PC+4); other writes happen in WB.
    assign w_rf_we = ((w_state == S_DECODE) && w_dec.legal && w_dec.jal) || (w_state == S_WB);
    assign w_waddr = w_dec.jal ? 5'd31 : (w_dec.rtype ? w_rd : w_rt);
    assign w_wdata = w_dec.jal ? r_pc : (w_dec.load ? r_mdr : r_aluout);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rf_we && (w_waddr != 5'd0)) begin
            r_rf[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc     <= PC_RESET;
            r_cur_pc <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (w_state)
                S_FETCH: begin
                    if (bus.imem_req && bus.imem_ready) begin
                        r_ir     <= bus.imem_rdata;
                        r_cur_pc <= r_pc;
                        r_pc     <= w_alu_y;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rs_data;
                    r_b      <= w_rt_data;
                    r_aluout <= w_alu_y;
                    if (w_dec.legal && w_dec.jump)
                        r_pc <= w_dec.jr ? w_rs_data : {r_pc[31:28], r_ir[25:0], 2'b00};
                end
                S_EXEC: begin
                    if (!w_dec.branch) r_aluout <= w_alu_y;
                    else if (w_taken)  r_pc     <= r_aluout;
                end
                S_MEM: begin
                    if (bus.dmem_ready && w_dec.load) r_mdr <= bus.dmem_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
module tb_mips_multicycle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0, n_ret = 0, base = 0;
    int d_lat = 3;
    int d_cnt;
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic [31:0] rpc  [64];
    int          rcyc [64];

    localparam int NPROG = 30;
    logic [31:0] PROG [NPROG] = '{
        32'h20010005, 32'h2002FFFD, 32'h00221821, 32'hAC030008, 32'h8C040008,
        32'hAC04000C, 32'h10210002, 32'hFC000000, 32'hFC000000, 32'h14210002,
        32'h0C00000C, 32'hFC000000, 32'hAC1F0010, 32'h0041302A, 32'hAC060014,
        32'h3C071234, 32'h34E75678, 32'hAC070018, 32'h24080054, 32'h01000008,
        32'hFC000000, 32'h00014900, 32'h00295023, 32'h314BFFFF, 32'hAC0B001C,
        32'hAC0A0020, 32'hAC090024, 32'h20000007, 32'hAC000028, 32'h8C0C0002};
    localparam int NRET = 25;
    logic [31:0] EXP_PC [NRET] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h24, 32'h28,
        32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h54,
        32'h58, 32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70};
    // cycles taken by each instruction (3 dmem wait states per access)
    int EXP_GAP [NRET] = '{0, 4, 4, 7, 8, 7, 3, 3, 2, 7, 4, 7, 4, 4, 7, 4, 2, 4, 4, 4, 7, 7, 7, 4, 7};
    int          EXP_DADDR [9] = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
    logic [31:0] EXP_DATA  [9] = '{32'h2, 32'h2, 32'h2C, 32'h1, 32'h12345678,
                                   32'h0000FFB5, 32'hFFFFFFB5, 32'h50, 32'h0};

    mips_mc_if #(.ADDR_W(10)) bus  ();
    mips_mc_if #(.ADDR_W(10)) tbus ();

    logic        retire, halted, t_retire, t_halted;
    logic [31:0] retire_pc, t_retire_pc;
    logic [1:0]  err_code, t_err;

    mips_multicycle #(.ADDR_W(10), .PC_RESET(32'h0), .TIMEOUT(255)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_retire(retire), .o_retire_pc(retire_pc), .o_halted(halted), .o_err_code(err_code));

    mips_multicycle #(.ADDR_W(10), .PC_RESET(32'h0), .TIMEOUT(4)) u_tmo (
        .i_clk(clk), .i_rst_n(rst_n), .bus(tbus),
        .o_retire(t_retire), .o_retire_pc(t_retire_pc), .o_halted(t_halted), .o_err_code(t_err));

    // memory models
    assign bus.imem_rdata  = imem[bus.imem_addr];
    assign bus.imem_ready  = bus.imem_req;
    assign bus.dmem_rdata  = dmem[bus.dmem_addr];
    assign bus.dmem_ready  = bus.dmem_req && (d_cnt >= d_lat);
    assign tbus.imem_rdata = 32'h0;
    assign tbus.imem_ready = 1'b0;
    assign tbus.dmem_rdata = 32'h0;
    assign tbus.dmem_ready = 1'b0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) d_cnt <= 0;
        else if (bus.dmem_req && !bus.dmem_ready) d_cnt <= d_cnt + 1;
        else d_cnt <= 0;

    always @(posedge clk)
        if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) dmem[bus.dmem_addr] <= bus.dmem_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (retire && n_ret < 64) begin
            rpc[n_ret]  = retire_pc;
            rcyc[n_ret] = cyc;
            n_ret++;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_imem_req"},  bus.imem_req, 0);
        chk({p, "_dmem_req"},  bus.dmem_req, 0);
        chk({p, "_dmem_we"},   bus.dmem_we, 0);
        chk({p, "_retire"},    retire, 0);
        chk({p, "_halted"},    halted, 0);
        chk({p, "_err"},       err_code, 0);
        chk({p, "_imem_addr"}, bus.imem_addr, 0);
        chk({p, "_dmem_addr"}, bus.dmem_addr, 0);
        chk({p, "_wdata"},     bus.dmem_wdata, 0);
        chk({p, "_rpc"},       retire_pc, 0);
    endtask

    task automatic wait_halt(input int lim, input string tag);
        int i = 0;
        while (!halted && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk(tag, halted, 1);
    endtask

    initial begin
        for (int i = 0; i < NPROG; i++) imem[i] = PROG[i];
        #12;
        chk_rst("rst");
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("req_after_rst", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 0);

        // TIMEOUT=4 instance, imem never ready
        repeat (3) @(negedge clk);
        chk("tmo_not_yet", t_halted, 0);
        @(negedge clk);
        chk("tmo_halted", t_halted, 1);
        chk("tmo_err", t_err, 2);
        chk("tmo_req_off", tbus.imem_req, 0);

        // main program ends with a misaligned lw
        wait_halt(2000, "prog_halt");
        chk("align_err", err_code, 3);
        chk("halt_ireq", bus.imem_req, 0);
        chk("halt_dreq", bus.dmem_req, 0);
        chk("n_retire", n_ret, NRET);
        for (int k = 0; k < NRET && k < n_ret; k++) begin
            chk($sformatf("rpc_%0d", k), rpc[k], EXP_PC[k]);
            if (k > 0) chk($sformatf("gap_%0d", k), rcyc[k] - rcyc[k-1], EXP_GAP[k]);
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("dmem_%0d", EXP_DADDR[k]), dmem[EXP_DADDR[k]], EXP_DATA[k]);

        // illegal opcode
        rst_n = 1'b0;
        imem[0] = 32'hFC000000;
        base = n_ret;
        @(negedge clk) rst_n = 1'b1;
        wait_halt(50, "ill_halt");
        chk("ill_err", err_code, 1);
        repeat (4) @(negedge clk);
        chk("ill_no_req", bus.imem_req, 0);
        chk("ill_no_retire", n_ret - base, 0);

        // reset while a load waits in MEM
        rst_n = 1'b0;
        imem[0] = 32'h8C040008;
        d_lat = 20;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20 && !bus.dmem_req; i++) @(negedge clk);
        chk("mem_req", bus.dmem_req, 1);
        chk("mem_addr", bus.dmem_addr, 2);
        chk("mem_we", bus.dmem_we, 0);
        repeat (2) @(negedge clk);
        base = n_ret;
        #2 rst_n = 1'b0;
        #1 chk_rst("midrst");
        repeat (2) @(negedge clk);
        chk("midrst_no_retire", n_ret - base, 0);
        rst_n = 1'b1;
        #1;
        chk("restart_req", bus.imem_req, 1);
        chk("restart_addr", bus.imem_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
